uart_cmd_host: RTL and testbench

Host-side initiator for the board's serial command responder. On a start pulse it serialises one command byte ('1' = 8'h31 or '2' = 8'h32) as 8N1, then receives the 4-byte ASCII reply. It checks the reply against the expected string ("CCNU" or "PLAC") and reports pass, fail or timeout. It is used as a bench/loopback master and as an on-chip self-test driver facing the responder's rs232 pins.

---
 rtl/uart_cmd_host.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: sends a one-byte command as 8N1 and checks the 4-byte ASCII reply.
// The reply line is synchronised before use. Reception happens only while waiting
// for or receiving reply bytes.
module uart_cmd_host #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmd_sel,
  input  logic        rs232_rx,
  output logic        rs232_tx,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] resp_data
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RX,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          cmd_q, cmd_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   resp_q, resp_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  logic          rx_fall;
  logic [31:0]   resp_new;
  logic [31:0]   resp_expect;

  assign rx_fall     = rx_prev_q & ~rx_sync_q;
  assign resp_expect = cmd_q ? 32'h504C4143 : 32'h43434E55;

  // Place the just-received byte into its slot; first byte lands in the top lane.
  always_comb begin
    resp_new = resp_q;
    case (byte_idx_q[1:0])
      2'd0:    resp_new[31:24] = rx_shift_q;
      2'd1:    resp_new[23:16] = rx_shift_q;
      2'd2:    resp_new[15:8]  = rx_shift_q;
      default: resp_new[7:0]   = rx_shift_q;
    endcase
  end

  // Next-state logic for the transaction FSM, the bit/timeout counters and outputs.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    tmo_cnt_d  = tmo_cnt_q;
    byte_idx_d = byte_idx_q;
    tx_byte_d  = tx_byte_q;
    rx_shift_d = rx_shift_q;
    cmd_d      = cmd_q;
    tx_d       = tx_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    resp_d     = resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SEND;
          cmd_d     = cmd_sel;
          tx_byte_d = cmd_sel ? 8'h32 : 8'h31;
          resp_d    = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      S_SEND: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            state_d    = S_WAIT;
            tmo_cnt_d  = '0;
            byte_idx_d = '0;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            // Bit index n carries data bit n-1; index 9 is the stop bit.
            tx_d = (bit_idx_q < 4'd8) ? tx_byte_q[bit_idx_q[2:0]] : 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (rx_fall) begin
          state_d   = S_RX;
          tmo_cnt_d = '0;
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_FIN;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_RX: begin
        if (bit_idx_q == 4'd0) begin
          // Half a bit after the falling edge: a high line means it was a glitch.
          if (bit_cnt_q == BIT_HALF) begin
            bit_cnt_d = '0;
            if (rx_sync_q) state_d = S_WAIT;
            else           bit_idx_d = 4'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            if (!rx_sync_q) begin
              state_d = S_FIN;
            end else begin
              resp_d     = resp_new;
              byte_idx_d = byte_idx_q + 3'd1;
              if (byte_idx_q == 3'd3) begin
                state_d = S_FIN;
                pass_d  = (resp_new == resp_expect);
              end else begin
                state_d   = S_WAIT;
                tmo_cnt_d = '0;
              end
            end
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  // State, counters, registered outputs and the rx synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      tmo_cnt_q  <= '0;
      byte_idx_q <= '0;
      tx_byte_q  <= '0;
      rx_shift_q <= '0;
      cmd_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      resp_q     <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      byte_idx_q <= byte_idx_d;
      tx_byte_q  <= tx_byte_d;
      rx_shift_q <= rx_shift_d;
      cmd_q      <= cmd_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      resp_q     <= resp_d;
      rx_meta_q  <= rs232_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign rs232_tx  = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign resp_data = resp_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host: table of reply scenarios plus hand sequences for
// timeout timing, glitch rejection, framing error and reset in mid-frame.
module tb_uart_cmd_host;

  localparam int CPB  = 8;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cmd_sel;
  logic        rs232_rx;
  logic        rs232_tx;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // captured at each done pulse
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          pulse_err = 0;
  logic        done_prev = 1'b0;
  logic        pass_at, to_at, busy_at;
  logic [31:0] resp_at;

  uart_cmd_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_sel   (cmd_sel),
    .rs232_rx  (rs232_rx),
    .rs232_tx  (rs232_tx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .resp_data (resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    done_prev <= done;
    if (done && done_prev) pulse_err <= pulse_err + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      pass_at  <= pass;
      to_at    <= timeout;
      busy_at  <= busy;
      resp_at  <= resp_data;
    end
  end

  typedef struct packed {
    logic        sel;
    logic [31:0] reply;
    logic [2:0]  n;
    logic [9:0]  gap;
    logic        exp_pass;
    logic        exp_to;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Pulse start and check the whole command frame at mid-bit.
  task automatic start_and_check_frame(input logic sel);
    logic [7:0] b;
    logic       exp_bit;
    b = sel ? 8'h32 : 8'h31;
    start   = 1'b1;
    cmd_sel = sel;
    tick();
    start   = 1'b0;
    cmd_sel = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      check($sformatf("tx_bit%0d", k), {31'd0, rs232_tx}, {31'd0, exp_bit});
      repeat (CPB) tick();
    end
  endtask

  // Drive one 8N1 byte on the reply line; n is the edge after which the start bit began.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int n);
    n = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      rs232_rx = 1'b0;
      else if (k == 9) rs232_rx = stop_bit;
      else             rs232_rx = b[k-1];
      repeat (CPB) tick();
    end
    rs232_rx = 1'b1;
  endtask

  task automatic wait_done(input int base, input int limit);
    int w;
    w = 0;
    while (done_cnt == base && w < limit) begin
      tick();
      w++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL done_wait: got no done after %0d cycles expected a done pulse", limit);
    end
  endtask

  initial begin
    int          base;
    int          n;
    logic [31:0] rep;

    vecs[0] = '{sel:1'b0, reply:32'h43434E55, n:3'd4, gap:10'd2,   exp_pass:1'b1, exp_to:1'b0, exp_resp:32'h43434E55};
    vecs[1] = '{sel:1'b1, reply:32'h504C4143, n:3'd4, gap:10'd500, exp_pass:1'b1, exp_to:1'b0, exp_resp:32'h504C4143};
    vecs[2] = '{sel:1'b0, reply:32'h43434E58, n:3'd4, gap:10'd2,   exp_pass:1'b0, exp_to:1'b0, exp_resp:32'h43434E58};
    vecs[3] = '{sel:1'b0, reply:32'h504C4143, n:3'd4, gap:10'd5,   exp_pass:1'b0, exp_to:1'b0, exp_resp:32'h504C4143};
    vecs[4] = '{sel:1'b1, reply:32'h43434E55, n:3'd4, gap:10'd5,   exp_pass:1'b0, exp_to:1'b0, exp_resp:32'h43434E55};

    rst      = 1'b1;
    start    = 1'b0;
    cmd_sel  = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) tick();
    check("rst_tx",      {31'd0, rs232_tx}, 32'd1);
    check("rst_busy",    {31'd0, busy},     32'd0);
    check("rst_done",    {31'd0, done},     32'd0);
    check("rst_pass",    {31'd0, pass},     32'd0);
    check("rst_timeout", {31'd0, timeout},  32'd0);
    check("rst_resp",    resp_data,         32'd0);
    rst = 1'b0;
    tick();

    // Table-driven reply scenarios
    for (int r = 0; r < 5; r++) begin
      base = done_cnt;
      start_and_check_frame(vecs[r].sel);
      repeat (3) tick();
      rep = vecs[r].reply;
      for (int i = 0; i < int'(vecs[r].n); i++) begin
        send_byte(rep[31-8*i -: 8], 1'b1, n);
        repeat (int'(vecs[r].gap)) tick();
      end
      wait_done(base, 4000);
      check($sformatf("v%0d_pass", r),    {31'd0, pass_at}, {31'd0, vecs[r].exp_pass});
      check($sformatf("v%0d_timeout", r), {31'd0, to_at},   {31'd0, vecs[r].exp_to});
      check($sformatf("v%0d_resp", r),    resp_at,          vecs[r].exp_resp);
      check($sformatf("v%0d_busy_at_done", r), {31'd0, busy_at}, 32'd0);
      repeat (5) tick();
      check($sformatf("v%0d_pass_held", r), {31'd0, pass}, {31'd0, vecs[r].exp_pass});
      check($sformatf("v%0d_idle_busy", r), {31'd0, busy}, 32'd0);
    end

    // Timeout after two bytes: stop bit of byte n is sampled 79 edges after its
    // start bit begins (2 sync + 1 detect + 4 half-bit + 9 bits of 8), then 1000 idle clks.
    base = done_cnt;
    start_and_check_frame(1'b0);
    repeat (3) tick();
    send_byte(8'h43, 1'b1, n);
    repeat (4) tick();
    send_byte(8'h43, 1'b1, n);
    wait_done(base, 3000);
    check("tmo_done_cycle", done_cyc,        n + 79 + TMO);
    check("tmo_timeout",    {31'd0, to_at},   32'd1);
    check("tmo_pass",       {31'd0, pass_at}, 32'd0);
    check("tmo_resp",       resp_at,          32'h43430000);
    repeat (5) tick();

    // Glitch in WAIT is rejected; a start while busy is ignored.
    base = done_cnt;
    start_and_check_frame(1'b0);
    repeat (3) tick();
    rs232_rx = 1'b0;
    repeat (2) tick();
    rs232_rx = 1'b1;
    repeat (20) tick();
    start   = 1'b1;
    cmd_sel = 1'b1;
    tick();
    start   = 1'b0;
    cmd_sel = 1'b0;
    repeat (5) tick();
    rep = 32'h43434E55;
    for (int i = 0; i < 4; i++) begin
      send_byte(rep[31-8*i -: 8], 1'b1, n);
      tick();
    end
    wait_done(base, 3000);
    check("glitch_pass", {31'd0, pass_at}, 32'd1);
    check("glitch_resp", resp_at,          32'h43434E55);
    repeat (5) tick();

    // Framing error on the first byte
    base = done_cnt;
    start_and_check_frame(1'b0);
    repeat (3) tick();
    send_byte(8'h43, 1'b0, n);
    wait_done(base, 3000);
    check("frame_pass",    {31'd0, pass_at}, 32'd0);
    check("frame_timeout", {31'd0, to_at},   32'd0);
    check("frame_resp",    resp_at,          32'd0);
    repeat (5) tick();

    // Reset in the middle of data bit 3 (tx bit index 4) of a command frame
    start   = 1'b1;
    cmd_sel = 1'b0;
    tick();
    start = 1'b0;
    repeat (33) tick();
    check("mid_tx_bit3", {31'd0, rs232_tx}, 32'd0);
    check("mid_busy",    {31'd0, busy},     32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_tx",   {31'd0, rs232_tx}, 32'd1);
    check("rstmid_busy", {31'd0, busy},     32'd0);
    rst = 1'b0;
    repeat (3) tick();
    base = done_cnt;
    start_and_check_frame(1'b1);
    repeat (3) tick();
    rep = 32'h504C4143;
    for (int i = 0; i < 4; i++) begin
      send_byte(rep[31-8*i -: 8], 1'b1, n);
      tick();
    end
    wait_done(base, 3000);
    check("after_rst_pass", {31'd0, pass_at}, 32'd1);
    check("after_rst_resp", resp_at,          32'h504C4143);
    repeat (3) tick();

    check("done_pulse_width", pulse_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
